mix_columns_stage: RTL and testbench

MIX_COLUMNS_STAGE -- requirements
Module: mix_columns_stage

---
 rtl/mix_columns_stage_pkg.sv | 17 +
 rtl/mix_columns_stage_if.sv | 24 ++
 rtl/mix_columns_stage_mix_single_column.sv | 21 ++
 rtl/mix_columns_stage.sv | 87 ++++++++
 tb/tb_mix_columns_stage.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_stage_pkg.sv
// Shared AES MixColumns constants and GF(2^8) helpers.
// All column arithmetic builds on xtime (multiply by 2 modulo x^8+x^4+x^3+x+1).
package mix_columns_stage_pkg;

    localparam int AES_BLK_W = 128;
    localparam int BYTE_W    = 8;
    localparam logic [BYTE_W-1:0] GF_POLY = 8'h1B;

    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? GF_POLY : '0);
    endfunction

    function automatic logic [BYTE_W-1:0] gf_mul3(input logic [BYTE_W-1:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

// File: rtl/mix_columns_stage_if.sv
// Stream handshake between shift-rows, mix-columns and the next round stage.
// Byte k of a state occupies bits [8k:8k+7]; byte 0 sits at bit 0.
interface mix_columns_stage_if;
    import mix_columns_stage_pkg::*;

    logic [0:AES_BLK_W-1] in;
    logic                 in_ready;
    logic                 last_round;
    logic                 in_hold;
    logic [0:AES_BLK_W-1] out;
    logic                 out_ready;
    logic                 out_hold;

    modport slave (
        input  in, in_ready, last_round, out_hold,
        output in_hold, out, out_ready
    );

    modport master (
        output in, in_ready, last_round, out_hold,
        input  in_hold, out, out_ready
    );

endinterface

// File: rtl/mix_columns_stage_mix_single_column.sv
// Combinational MixColumns on one 32-bit column; a0 (row 0) is the top byte.
module mix_single_column
    import mix_columns_stage_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [BYTE_W-1:0] w_a0, w_a1, w_a2, w_a3;
    logic [BYTE_W-1:0] w_b0, w_b1, w_b2, w_b3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_b0 = xtime(w_a0) ^ gf_mul3(w_a1) ^ w_a2 ^ w_a3;
    assign w_b1 = w_a0 ^ xtime(w_a1) ^ gf_mul3(w_a2) ^ w_a3;
    assign w_b2 = w_a0 ^ w_a1 ^ xtime(w_a2) ^ gf_mul3(w_a3);
    assign w_b3 = gf_mul3(w_a0) ^ w_a1 ^ w_a2 ^ xtime(w_a3);

    assign o_col = {w_b0, w_b1, w_b2, w_b3};

endmodule

// File: rtl/mix_columns_stage.sv
// Two-stage AES MixColumns pipeline with elastic backpressure and a handoff counter.
// S1 registers the incoming state; S2 holds the mixed (or bypassed) result.
module mix_columns_stage
    import mix_columns_stage_pkg::*;
#(
    parameter int LAST_ROUND_BYPASS = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             reset,
    mix_columns_stage_if.slave bus,
    output logic [CNT_W-1:0] block_cnt
);

    logic [0:AES_BLK_W-1] r_data_p1;
    logic                 r_last_p1;
    logic                 r_vld_p1;
    logic [0:AES_BLK_W-1] r_data_p2;
    logic                 r_vld_p2;
    logic [CNT_W-1:0]     r_block_cnt;

    logic                 w_stall;
    logic                 w_accept;
    logic                 w_advance;
    logic [0:AES_BLK_W-1] w_mixed;
    logic [0:AES_BLK_W-1] w_result;

    // A full S1 can only be refilled if S2 drains it this cycle.
    assign w_stall   = r_vld_p2 & bus.out_hold;
    assign w_advance = r_vld_p1 & ~w_stall;
    assign w_accept  = bus.in_ready & ~bus.in_hold;

    assign bus.in_hold   = r_vld_p1 & w_stall;
    assign bus.out       = r_data_p2;
    assign bus.out_ready = r_vld_p2;
    assign block_cnt     = r_block_cnt;

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_column u_col (
            .i_col (r_data_p1[32*c +: 32]),
            .o_col (w_mixed[32*c +: 32])
        );
    end

    assign w_result = (LAST_ROUND_BYPASS != 0 && r_last_p1) ? r_data_p1 : w_mixed;

    // ---- S1: capture ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p1  <= 1'b1;
            r_last_p1 <= bus.last_round;
        end else if (w_advance) begin
            r_vld_p1  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data_p1 <= bus.in;
        end
    end

    // ---- S2: mixed result, frozen while stalled ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
        end else if (!w_stall) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_result;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_block_cnt <= '0;
        end else if (r_vld_p2 && !bus.out_hold) begin
            r_block_cnt <= r_block_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mix_columns_stage.sv
// Directed bench for mix_columns_stage: known AES column vectors, bypass,
// backpressure stream, counter wrap and mid-flight reset.
module tb_mix_columns_stage;

    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] block_cnt;

    mix_columns_stage_if bus_if ();

    mix_columns_stage #(
        .LAST_ROUND_BYPASS (1),
        .CNT_W             (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_if.slave),
        .block_cnt (block_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [0:127] din;
        logic         last;
        logic [0:127] dout;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] col_in  [6];
    logic [31:0] col_out [6];
    logic [0:127] st_in  [5];
    logic [0:127] st_exp [5];

    initial begin
        vecs[0] = '{128'hdb135345_00000000_00000000_00000000, 1'b0,
                    128'h8e4da1bc_00000000_00000000_00000000};
        vecs[1] = '{128'hf20a225c_01010101_c6c6c6c6_2d26314c, 1'b0,
                    128'h9fdc589d_01010101_c6c6c6c6_4d7ebdf8};
        vecs[2] = '{128'hdb135345_00000000_00000000_00000000, 1'b1,
                    128'hdb135345_00000000_00000000_00000000};
        vecs[3] = '{128'hf20a225c_01010101_c6c6c6c6_2d26314c, 1'b1,
                    128'hf20a225c_01010101_c6c6c6c6_2d26314c};

        col_in[0] = 32'hdb135345; col_out[0] = 32'h8e4da1bc;
        col_in[1] = 32'hf20a225c; col_out[1] = 32'h9fdc589d;
        col_in[2] = 32'h01010101; col_out[2] = 32'h01010101;
        col_in[3] = 32'hc6c6c6c6; col_out[3] = 32'hc6c6c6c6;
        col_in[4] = 32'h2d26314c; col_out[4] = 32'h4d7ebdf8;
        col_in[5] = 32'h00000000; col_out[5] = 32'h00000000;
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 4; c++) begin
                st_in[i][32*c +: 32]  = col_in[(i + c) % 6];
                st_exp[i][32*c +: 32] = col_out[(i + c) % 6];
            end
        end

        bus_if.in         = '0;
        bus_if.in_ready   = 1'b0;
        bus_if.last_round = 1'b0;
        bus_if.out_hold   = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_out_ready", 128'(bus_if.out_ready), 128'd0);
        check("reset_block_cnt", 128'(block_cnt), 128'd0);
        check("reset_in_hold", 128'(bus_if.in_hold), 128'd0);
        check("reset_out", bus_if.out, 128'd0);
        reset = 1'b0;

        // Single states with exact 2-cycle latency
        for (int v = 0; v < 4; v++) begin
            @(negedge clk);
            bus_if.in         = vecs[v].din;
            bus_if.last_round = vecs[v].last;
            bus_if.in_ready   = 1'b1;
            @(negedge clk);
            bus_if.in_ready = 1'b0;
            check($sformatf("vec%0d_lat1", v), 128'(bus_if.out_ready), 128'd0);
            @(negedge clk);
            check($sformatf("vec%0d_ready", v), 128'(bus_if.out_ready), 128'd1);
            check($sformatf("vec%0d_out", v), bus_if.out, vecs[v].dout);
            @(negedge clk);
            check($sformatf("vec%0d_drop", v), 128'(bus_if.out_ready), 128'd0);
        end
        check("table_block_cnt", 128'(block_cnt), 128'd4);

        // Fill both stages under backpressure, then reset asynchronously
        bus_if.out_hold   = 1'b1;
        bus_if.last_round = 1'b0;
        bus_if.in         = vecs[0].din;
        bus_if.in_ready   = 1'b1;
        @(negedge clk);
        bus_if.in = vecs[1].din;
        @(negedge clk);
        bus_if.in_ready = 1'b0;
        check("prereset_in_hold", 128'(bus_if.in_hold), 128'd1);
        #2 reset = 1'b1;
        #1;
        check("async_out_ready", 128'(bus_if.out_ready), 128'd0);
        check("async_block_cnt", 128'(block_cnt), 128'd0);
        check("async_in_hold", 128'(bus_if.in_hold), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_if.out_hold = 1'b0;
        begin
            int leaked = 0;
            repeat (5) begin
                @(negedge clk);
                if (bus_if.out_ready) leaked++;
            end
            check("flush_no_output", 128'(leaked), 128'd0);
        end

        // Back-to-back stream with a 3-cycle stall in the middle
        begin
            int sent = 0;
            int got = 0;
            int saw_in_hold = 0;
            logic [0:127] held;
            for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
                @(negedge clk);
                bus_if.out_hold = (cyc >= 3 && cyc <= 5);
                bus_if.in_ready = (sent < 5);
                bus_if.in       = (sent < 5) ? st_in[sent] : '0;
                #1;
                if (bus_if.in_hold) saw_in_hold++;
                if (cyc == 3) held = bus_if.out;
                if (cyc == 4 || cyc == 5) begin
                    check($sformatf("stall_ready_c%0d", cyc), 128'(bus_if.out_ready), 128'd1);
                    check($sformatf("stall_out_c%0d", cyc), bus_if.out, held);
                end
                if (bus_if.out_ready && !bus_if.out_hold) begin
                    if (got < 5) check($sformatf("stream_out%0d", got), bus_if.out, st_exp[got]);
                    got++;
                end
                if (bus_if.in_ready && !bus_if.in_hold) sent++;
            end
            bus_if.in_ready = 1'b0;
            bus_if.out_hold = 1'b0;
            check("stream_count", 128'(got), 128'd5);
            check("stream_in_hold_seen", 128'(saw_in_hold != 0), 128'd1);
            @(negedge clk);
            check("stream_block_cnt", 128'(block_cnt), 128'd5);
            check("stream_idle", 128'(bus_if.out_ready), 128'd0);
        end

        // Counter wrap: all-ones after 2^CNT_W-1 transfers, then zero
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus_if.in       = vecs[0].din;
        bus_if.in_ready = 1'b1;
        repeat ((1 << CNT_W) - 1) @(negedge clk);
        bus_if.in_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("cnt_all_ones", 128'(block_cnt), 128'((1 << CNT_W) - 1));
        bus_if.in_ready = 1'b1;
        @(negedge clk);
        bus_if.in_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("cnt_wrap", 128'(block_cnt), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
